// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multicycle ALU execution stage.
// The op codes match the ones ALUControl produces. 4'b1001 is ALUControl's
// fall-through default, and this block treats it as an invalid op.
package alu_multicycle_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_LUI     = 4'b0101;
    localparam logic [3:0] OP_SLL     = 4'b0110;
    localparam logic [3:0] OP_SRL     = 4'b0111;
    localparam logic [3:0] OP_MULT    = 4'b1000;
    localparam logic [3:0] OP_INVALID = 4'b1001;

    // Execution class decides which path the FSM takes after accept.
    typedef enum logic [1:0] {
        CLS_SINGLE  = 2'd0,
        CLS_SHIFT   = 2'd1,
        CLS_MULT    = 2'd2,
        CLS_INVALID = 2'd3
    } op_class_t;

    function automatic logic op_is_valid(input logic [3:0] op);
        return op <= OP_MULT;
    endfunction

    function automatic logic op_is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

    function automatic op_class_t op_class(input logic [3:0] op);
        if (!op_is_valid(op)) begin
            return CLS_INVALID;
        end else if (op_is_shift(op)) begin
            return CLS_SHIFT;
        end else if (op == OP_MULT) begin
            return CLS_MULT;
        end else begin
            return CLS_SINGLE;
        end
    endfunction

endpackage

// File: rtl/alu_multicycle_mult_shift_add.sv
// Iterative unsigned shift-add multiplier. It keeps only the low WIDTH bits.
// The load cycle already performs the first partial-product step.
// Then WIDTH-1 further steps follow, so the WIDTH-bit product is ready
// on the first cycle busy reads low after load.
module mult_shift_add
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] product_lo
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    // On load, seed the operands and do step 0. After that, do one add/shift step per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= b[0] ? a : '0;
            a_r <= a << 1;
            b_r <= b >> 1;
            cnt <= CW'(WIDTH - 1);
        end else if (cnt != '0) begin
            if (b_r[0]) begin
                acc <= acc + a_r;
            end
            a_r <= a_r << 1;
            b_r <= b_r >> 1;
            cnt <= cnt - CW'(1);
        end
    end

    assign busy       = (cnt != '0);
    assign product_lo = acc;

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU execution stage, downstream of ALUControl.
// Logic, add and LUI ops complete in one cycle. Shifts move one bit per cycle.
// MULT uses the iterative shift-add multiplier. Results are registered
// and change only when the op completes, which is the cycle done is high.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | waiting for start; single-cycle, invalid and zero-shift ops
//        | resolve here and go straight to DONE
//  SHIFT | shifting latched operand one bit per cycle, busy=1
//  MUL   | multiplier iterating, busy=1
//  DONE  | one-cycle done pulse with result valid; start ignored
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             invalid_op
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] MUL   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    op_class_t        cls;
    logic             mul_load;
    logic             mul_busy;
    logic [WIDTH-1:0] mul_product;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] sh_val;
    logic [SHW-1:0]   sh_cnt;
    logic [WIDTH-1:0] sh_step;

    logic [WIDTH-1:0] cap_val;
    logic             cap_inv;

    // LUI is written as a shift so it stays legal when WIDTH == 16.
    function automatic logic [WIDTH-1:0] single_result(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_LUI:  r = {{(WIDTH-16){1'b0}}, b[15:0]} << (WIDTH - 16);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign cls     = op_class(ALUOperation);
    assign sh_step = (op_q == OP_SLL) ? (sh_val << 1) : (sh_val >> 1);

    mult_shift_add #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk        (clk),
        .reset      (reset),
        .load       (mul_load),
        .a          (A),
        .b          (B),
        .busy       (mul_busy),
        .product_lo (mul_product)
    );

    // Next-state decode. The multiplier is loaded on the accept cycle of a MULT.
    always_comb begin
        state_nxt = state;
        mul_load  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (cls)
                        CLS_SHIFT: state_nxt = (shamt == '0) ? DONE : SHIFT;
                        CLS_MULT: begin
                            state_nxt = MUL;
                            mul_load  = 1'b1;
                        end
                        default:   state_nxt = DONE;
                    endcase
                end
            end
            SHIFT: begin
                if (sh_cnt == SHW'(1)) begin
                    state_nxt = DONE;
                end
            end
            MUL: begin
                if (!mul_busy) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pick the value that gets registered on the edge that enters DONE.
    always_comb begin
        cap_val = '0;
        cap_inv = 1'b0;
        case (state)
            IDLE: begin
                case (cls)
                    CLS_SINGLE:  cap_val = single_result(ALUOperation, A, B);
                    CLS_SHIFT:   cap_val = A;
                    CLS_INVALID: cap_inv = 1'b1;
                    default:     cap_val = '0;
                endcase
            end
            SHIFT:   cap_val = sh_step;
            MUL:     cap_val = mul_product;
            default: cap_val = '0;
        endcase
    end

    // State register. A reset at any point aborts the current op without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the op and shift operand on accept, then shift one bit per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            sh_val <= '0;
            sh_cnt <= '0;
        end else if (state == IDLE && start) begin
            op_q   <= ALUOperation;
            sh_val <= A;
            sh_cnt <= shamt;
        end else if (state == SHIFT) begin
            sh_val <= sh_step;
            sh_cnt <= sh_cnt - SHW'(1);
        end
    end

    // The result, Zero and invalid flag update only on the edge that completes an op.
    always_ff @(posedge clk) begin
        if (reset) begin
            ALUResult  <= '0;
            Zero       <= 1'b1;
            invalid_op <= 1'b0;
        end else if (state != DONE && state_nxt == DONE) begin
            ALUResult  <= cap_val;
            Zero       <= (cap_val == '0);
            invalid_op <= cap_inv;
        end
    end

    assign busy = (state == SHIFT) || (state == MUL);
    assign done = (state == DONE);

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle. A cycle-level behavioural model tracks the
// expected busy/done/result values from the op semantics and latencies.
// A negedge checker compares the DUT against the model on every cycle.
// Directed ops with hand-computed results pin the model itself.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  ALUOperation = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        invalid_op;

    int total = 0;
    int bad   = 0;

    alu_multicycle #(
        .WIDTH(32),
        .SHW  (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .shamt        (shamt),
        .busy         (busy),
        .done         (done),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .invalid_op   (invalid_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state: cycles still to run, done pulse, visible result, and the pending result of the running op.
    typedef struct packed {
        logic [5:0]  cnt;
        logic        done;
        logic [31:0] res;
        logic        inv;
        logic [31:0] p_res;
        logic        p_inv;
    } mstate_t;

    mstate_t m = '0;
    logic started = 1'b0;

    function automatic mstate_t model_next(input mstate_t cur, input logic rst, input logic st,
                                           input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        mstate_t n;
        logic [31:0] r;
        logic iv;
        int lat;
        n = cur;
        if (rst) begin
            n = '0;
            return n;
        end
        if (cur.done) begin
            n.done = 1'b0;
            return n;
        end
        if (cur.cnt != 0) begin
            n.cnt = cur.cnt - 6'd1;
            if (n.cnt == 0) begin
                n.done = 1'b1;
                n.res  = cur.p_res;
                n.inv  = cur.p_inv;
            end
            return n;
        end
        if (st) begin
            iv  = 1'b0;
            lat = 1;
            case (op)
                4'd0: r = a & b;
                4'd1: r = a | b;
                4'd2: r = ~(a | b);
                4'd3: r = a + b;
                4'd4: r = a - b;
                4'd5: r = {b[15:0], 16'h0000};
                4'd6: begin r = a << sh; lat = int'(sh) + 1; end
                4'd7: begin r = a >> sh; lat = int'(sh) + 1; end
                4'd8: begin r = a * b;   lat = 33;           end
                default: begin r = 32'd0; iv = 1'b1; end
            endcase
            n.p_res = r;
            n.p_inv = iv;
            if (lat == 1) begin
                n.done = 1'b1;
                n.res  = r;
                n.inv  = iv;
            end else begin
                n.cnt = 6'(lat - 1);
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m       <= model_next(m, reset, start, ALUOperation, A, B, shamt);
        started <= 1'b1;
    end

    // Compare the DUT with the model on every cycle once the model has seen a clock edge.
    always @(negedge clk) begin
        if (started) begin
            chk("cyc busy",   32'(busy),       32'(m.cnt != 0));
            chk("cyc done",   32'(done),       32'(m.done));
            chk("cyc result", ALUResult,       m.res);
            chk("cyc zero",   32'(Zero),       32'(m.res == 32'd0));
            chk("cyc inv",    32'(invalid_op), 32'(m.inv));
        end
    end

    // Issue one op, optionally hammer the inputs while it is busy, and check its latency and result.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_r,
                          input int exp_lat, input logic exp_inv, input bit noisy);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        #1;
        ALUOperation = op;
        A = a;
        B = b;
        shamt = sh;
        start = 1'b1;
        held = ALUResult;
        @(negedge clk);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (noisy) begin
                chk({name, " held"}, ALUResult, held);
            end
            #1;
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                A = $urandom;
                B = $urandom;
                ALUOperation = 4'($urandom_range(0, 15));
                shamt = 5'($urandom_range(0, 31));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " result"}, ALUResult, exp_r);
        chk({name, " zero"}, 32'(Zero), 32'(exp_r == 32'd0));
        chk({name, " inv"}, 32'(invalid_op), 32'(exp_inv));
        #1;
        start = 1'b0;
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", ALUResult, 32'd0);
        chk("reset zero", 32'(Zero), 32'd1);
        chk("reset inv", 32'(invalid_op), 32'd0);
        #1;
        reset = 1'b0;

        run_op("add wrap", 4'b0011, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1, 1'b0, 1'b0);
        run_op("sub neg", 4'b0100, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1, 1'b0, 1'b0);
        run_op("lui", 4'b0101, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 32'h1234_0000, 1, 1'b0, 1'b0);
        run_op("nor", 4'b0010, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        run_op("sll 31", 4'b0110, 32'h1, 32'h0, 5'd31, 32'h8000_0000, 32, 1'b0, 1'b0);
        run_op("srl 0", 4'b0111, 32'hA5A5_0F0F, 32'h0, 5'd0, 32'hA5A5_0F0F, 1, 1'b0, 1'b0);
        run_op("srl 4", 4'b0111, 32'h8000_00F0, 32'h0, 5'd4, 32'h0800_000F, 5, 1'b0, 1'b1);
        run_op("mult", 4'b1000, 32'h0001_0001, 32'h0001_0001, 5'd0, 32'h0002_0001, 33, 1'b0, 1'b1);
        run_op("invalid", 4'b1001, 32'h1234_5678, 32'h1, 5'd0, 32'h0, 1, 1'b1, 1'b0);
        run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1, 1'b0, 1'b0);

        // Reset in the middle of a MULT must abort it with no done pulse.
        @(negedge clk);
        #1;
        ALUOperation = 4'b1000;
        A = 32'h0000_0003;
        B = 32'h0000_0005;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid-mult busy", 32'(busy), 32'd1);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort result", ALUResult, 32'd0);
        chk("abort zero", 32'(Zero), 32'd1);
        #1;
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("abort no done", 32'(pulses), 32'd0);

        // Random traffic, including starts during busy/DONE, invalid codes and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #1;
            reset = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 2) == 0);
            ALUOperation = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                                       : 4'($urandom_range(0, 8));
            A = $urandom;
            B = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            shamt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(0, 3));
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
